// File: rtl/taglist_pkg.sv
// Shared tag-word layout, FSM states and record type for the taglist generator and reader.
// The generator packs with pack_tag(); the reader decodes with unpack_tag().
package taglist_pkg;

   localparam int RSV_LSB   = 28;
   localparam int RSV_W     = 4;
   localparam int SEQ_LSB   = 21;
   localparam int SEQ_W     = 7;
   localparam int START_LSB = 11;
   localparam int END_LSB   = 1;
   localparam int ADDR_W    = 10;
   localparam int EOF_BIT   = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TAG_RD,
      ST_TAG_WAIT,
      ST_TAG_CHK,
      ST_STREAM,
      ST_DRAIN
   } state_t;

   typedef struct packed {
      logic [SEQ_W-1:0]  seq;
      logic [ADDR_W-1:0] start_addr;
      logic [ADDR_W-1:0] end_addr;
      logic              eof;
   } tag_rec_t;

   function automatic tag_rec_t unpack_tag(input logic [31:0] w);
      tag_rec_t r;
      r.seq        = w[SEQ_LSB +: SEQ_W];
      r.start_addr = w[START_LSB +: ADDR_W];
      r.end_addr   = w[END_LSB +: ADDR_W];
      r.eof        = w[EOF_BIT];
      return r;
   endfunction

   function automatic logic [31:0] pack_tag(input tag_rec_t r);
      logic [31:0] w;
      w                      = '0;
      w[SEQ_LSB +: SEQ_W]    = r.seq;
      w[START_LSB +: ADDR_W] = r.start_addr;
      w[END_LSB +: ADDR_W]   = r.end_addr;
      w[EOF_BIT]             = r.eof;
      return w;
   endfunction

endpackage

// File: rtl/taglist_skid_buf.sv
// Two-entry data/last/seq buffer that absorbs the one-cycle ROM read latency.
// The producer reads 'count' to decide when it may issue another read.
module taglist_skid_buf
   import taglist_pkg::*;
#(
   parameter int DW = 8,
   parameter int SW = 7
) (
   input  logic          clk_50MHz,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   input  logic [SW-1:0] in_seq,
   output logic [1:0]    count,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic [SW-1:0] out_seq,
   input  logic          out_ready
);

   localparam int EW = DW + SW + 1;

   logic [EW-1:0] mem_q [2];
   logic [EW-1:0] mem_d [2];
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [1:0]    count_q, count_d;
   logic          push, pop;
   logic [EW-1:0] head;

   assign push      = in_valid && (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign pop       = out_valid && out_ready;
   assign count     = count_q;
   // Outputs read as zero while empty so reset leaves the stream port quiet.
   assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
   assign {out_data, out_last, out_seq} = head;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = {in_data, in_last, in_seq};
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/taglist_reader.sv
// Looks up tag records and replays each sequence's ROM range as a valid/ready word stream.
// Define TAGLIST_READER_CHECK_EN to also reject tags with nonzero [31:28] or start > end.
module taglist_reader
   import taglist_pkg::*;
#(
   parameter int TAG_AW = 7,
   parameter int ROM_AW = 10,
   parameter int ROM_DW = 8
) (
   input  logic              clk_50MHz,
   input  logic              reset,
   input  logic              start,
   input  logic              play_all,
   input  logic [TAG_AW-1:0] req_seq,
   output logic              tag_rd_en,
   output logic [TAG_AW-1:0] tag_addr,
   input  logic [31:0]       tag_data,
   output logic              rom_rd_en,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [ROM_DW-1:0] rom_data,
   output logic [ROM_DW-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [TAG_AW-1:0] out_seq,
   output logic              busy,
   output logic              done,
   output logic              not_found
);

   state_t            state_q, state_d;
   logic [TAG_AW-1:0] tag_addr_q, tag_addr_d;
   logic              play_all_q, play_all_d;
   logic [31:0]       tag_word_q, tag_word_d;
   logic [ROM_AW-1:0] cur_q, cur_d;
   logic              pend_q, pend_d;
   logic              pend_last_q, pend_last_d;
   logic              done_q, done_d;
   logic              not_found_q, not_found_d;
   tag_rec_t          rec;
   logic              rec_bad;
   logic [1:0]        sb_count;
   logic [2:0]        occ;
   logic              pop;

   assign rec = unpack_tag(tag_word_q);

`ifdef TAGLIST_READER_CHECK_EN
   assign rec_bad = (rec.seq != tag_addr_q) ||
                    (tag_word_q[RSV_LSB +: RSV_W] != '0) ||
                    (rec.start_addr > rec.end_addr);
`else
   logic unused_rsv;
   assign unused_rsv = ^tag_word_q[RSV_LSB +: RSV_W];
   assign rec_bad    = (rec.seq != tag_addr_q);
`endif

   // Buffer occupancy after this edge; a read issued now lands next cycle and must fit.
   assign pop       = out_valid && out_ready;
   assign occ       = 3'(sb_count) + 3'(pend_q) - 3'(pop);
   assign busy      = (state_q != ST_IDLE);
   assign tag_addr  = tag_addr_q;
   assign rom_addr  = cur_q;
   assign done      = done_q;
   assign not_found = not_found_q;

   always_comb begin
      state_d     = state_q;
      tag_addr_d  = tag_addr_q;
      play_all_d  = play_all_q;
      tag_word_d  = tag_word_q;
      cur_d       = cur_q;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
      done_d      = 1'b0;
      not_found_d = 1'b0;
      tag_rd_en   = 1'b0;
      rom_rd_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               tag_addr_d = play_all ? '0 : req_seq;
               play_all_d = play_all;
               state_d    = ST_TAG_RD;
            end
         end
         ST_TAG_RD: begin
            tag_rd_en = 1'b1;
            state_d   = ST_TAG_WAIT;
         end
         ST_TAG_WAIT: begin
            tag_word_d = tag_data;
            state_d    = ST_TAG_CHK;
         end
         ST_TAG_CHK: begin
            if (rec_bad) begin
               not_found_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               cur_d   = rec.start_addr;
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (occ <= 3'd1) begin
               rom_rd_en   = 1'b1;
               pend_d      = 1'b1;
               pend_last_d = (cur_q == rec.end_addr);
               cur_d       = cur_q + ROM_AW'(1);
               if (cur_q == rec.end_addr) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && out_last) begin
               if (play_all_q && !rec.eof && (tag_addr_q != '1)) begin
                  tag_addr_d = tag_addr_q + TAG_AW'(1);
                  state_d    = ST_TAG_RD;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tag_addr_q  <= '0;
         play_all_q  <= 1'b0;
         tag_word_q  <= '0;
         cur_q       <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         done_q      <= 1'b0;
         not_found_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tag_addr_q  <= tag_addr_d;
         play_all_q  <= play_all_d;
         tag_word_q  <= tag_word_d;
         cur_q       <= cur_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         done_q      <= done_d;
         not_found_q <= not_found_d;
      end
   end

   taglist_skid_buf #(
      .DW (ROM_DW),
      .SW (TAG_AW)
   ) u_skid (
      .clk_50MHz (clk_50MHz),
      .reset     (reset),
      .in_valid  (pend_q),
      .in_data   (rom_data),
      .in_last   (pend_last_q),
      .in_seq    (rec.seq),
      .count     (sb_count),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_seq   (out_seq),
      .out_ready (out_ready)
   );

endmodule

// File: tb/tb_taglist_reader.sv
// Scoreboard bench for taglist_reader: a tag-table model queues expected words, a monitor pops them.
// Honours TAGLIST_READER_CHECK_EN in the same way as the design.
module tb_taglist_reader;
   import taglist_pkg::*;

   logic        clk_50MHz = 1'b0;
   logic        reset     = 1'b1;
   logic        start     = 1'b0;
   logic        play_all  = 1'b0;
   logic [6:0]  req_seq   = '0;
   logic        tag_rd_en;
   logic [6:0]  tag_addr;
   logic [31:0] tag_data  = '0;
   logic        rom_rd_en;
   logic [9:0]  rom_addr;
   logic [7:0]  rom_data  = '0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_last;
   logic [6:0]  out_seq;
   logic        busy, done, not_found;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic [6:0] seq;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] tagMem [128];
   logic [7:0]  romMem [1024];
   int          assertCount   = 0;
   int          failCount     = 0;
   int          acceptedCount = 0;
   bit          randReady     = 1'b0;
   bit          expNf;

   always #10 clk_50MHz = ~clk_50MHz;

   taglist_reader dut (
      .clk_50MHz (clk_50MHz),
      .reset     (reset),
      .start     (start),
      .play_all  (play_all),
      .req_seq   (req_seq),
      .tag_rd_en (tag_rd_en),
      .tag_addr  (tag_addr),
      .tag_data  (tag_data),
      .rom_rd_en (rom_rd_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_seq   (out_seq),
      .busy      (busy),
      .done      (done),
      .not_found (not_found)
   );

   // Synchronous-read memories: data appears the cycle after the strobe.
   always @(posedge clk_50MHz) begin
      if (tag_rd_en) tag_data <= tagMem[tag_addr];
      if (rom_rd_en) rom_data <= romMem[rom_addr];
   end

   always begin
      @(posedge clk_50MHz);
      #1;
      out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] mkTag(input int seq, input int s, input int e, input bit eof);
      tag_rec_t r;
      r.seq        = 7'(seq);
      r.start_addr = 10'(s);
      r.end_addr   = 10'(e);
      r.eof        = eof;
      return pack_tag(r);
   endfunction

   // Reference model: walk the tag table and ROM directly, one word per address visited.
   task automatic modelOp(input bit pa, input int rs, output bit nf);
      int          e, sq, s, en, a;
      logic [31:0] w;
      bit          eofb, bad;
      e  = pa ? 0 : rs;
      nf = 1'b0;
      forever begin
         w    = tagMem[e];
         sq   = int'(w[27:21]);
         s    = int'(w[20:11]);
         en   = int'(w[10:1]);
         eofb = w[0];
         bad  = (sq != e);
`ifdef TAGLIST_READER_CHECK_EN
         if (w[31:28] != 4'd0 || s > en) bad = 1'b1;
`endif
         if (bad) begin
            nf = 1'b1;
            return;
         end
         a = s;
         forever begin
            expQ.push_back('{data: romMem[a], last: (a == en), seq: 7'(e)});
            if (a == en) break;
            a = (a + 1) % 1024;
         end
         if (!pa || eofb || e == 127) return;
         e++;
      end
   endtask

   task automatic applyStimulus(input bit pa, input int rs);
      modelOp(pa, rs, expNf);
      @(posedge clk_50MHz);
      #1;
      start    = 1'b1;
      play_all = pa;
      req_seq  = 7'(rs);
      @(posedge clk_50MHz);
      #1;
      start = 1'b0;
      checkOutput("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic waitDone(input string name);
      int n;
      n = 0;
      while (n < 3000) begin
         @(negedge clk_50MHz);
         n++;
         if (done || not_found) break;
      end
      if (n >= 3000) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL %s timeout: no done/not_found within %0d cycles", name, n);
         expQ.delete();
      end else begin
         checkOutput({name, "_done"}, 32'(done), 32'(!expNf));
         checkOutput({name, "_not_found"}, 32'(not_found), 32'(expNf));
         checkOutput({name, "_busy_end"}, 32'(busy), 32'd0);
         checkOutput({name, "_words_left"}, 32'(expQ.size()), 32'd0);
         @(negedge clk_50MHz);
         checkOutput({name, "_pulse_width"}, 32'(done | not_found), 32'd0);
      end
   endtask

   task automatic runOp(input string name, input bit pa, input int rs);
      applyStimulus(pa, rs);
      waitDone(name);
   endtask

   // Monitor: pop and compare on each handshake, and check words hold while stalled.
   initial begin
      logic       prevValid, prevReady;
      logic [15:0] prevWord;
      exp_t       e;
      prevValid = 1'b0;
      prevReady = 1'b0;
      prevWord  = '0;
      forever begin
         @(negedge clk_50MHz);
         if (reset) begin
            prevValid = 1'b0;
         end else begin
            if (prevValid && !prevReady && out_valid)
               checkOutput("hold_stable", 32'({out_data, out_last, out_seq}), 32'(prevWord));
            if (out_valid && out_ready) begin
               if (expQ.size() == 0) begin
                  assertCount++;
                  failCount++;
                  $display("[TB] FAIL spurious_word: got data 0x%0h seq %0d with nothing expected", out_data, out_seq);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("word_data_last_seq", 32'({out_data, out_last, out_seq}),
                              32'({e.data, e.last, e.seq}));
               end
               acceptedCount++;
            end
            prevValid = out_valid;
            prevReady = out_ready;
            prevWord  = {out_data, out_last, out_seq};
         end
      end
   end

   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int seq, s, len, n;
      for (int k = 0; k < 128; k++) tagMem[k] = '0;
      for (int k = 0; k < 1024; k++) romMem[k] = 8'($urandom);

      repeat (3) @(posedge clk_50MHz);
      #1;
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_not_found", 32'(not_found), 32'd0);
      checkOutput("reset_tag_rd_en", 32'(tag_rd_en), 32'd0);
      checkOutput("reset_rom_rd_en", 32'(rom_rd_en), 32'd0);
      reset = 1'b0;

      $display("[TB] single lookup");
      tagMem[3] = mkTag(3, 10, 13, 0);
      runOp("single", 1'b0, 3);

      $display("[TB] missing entry");
      tagMem[5] = mkTag(0, 20, 22, 0);
      runOp("not_found", 1'b0, 5);

      $display("[TB] play all");
      tagMem[0] = mkTag(0, 0, 1, 0);
      tagMem[1] = mkTag(1, 2, 4, 0);
      tagMem[2] = mkTag(2, 5, 5, 1);
      runOp("play_all", 1'b1, 0);

      $display("[TB] backpressure");
      tagMem[40] = mkTag(40, 100, 163, 0);
      randReady = 1'b1;
      runOp("backpressure", 1'b0, 40);
      randReady = 1'b0;

      $display("[TB] reset mid-stream");
      tagMem[20] = mkTag(20, 200, 209, 0);
      acceptedCount = 0;
      applyStimulus(1'b0, 20);
      n = 0;
      while (acceptedCount < 2 && n < 200) begin
         @(posedge clk_50MHz);
         #1;
         n++;
      end
      checkOutput("reset_mid_reached_word2", 32'(acceptedCount >= 2), 32'd1);
      reset = 1'b1;
      @(posedge clk_50MHz);
      #1;
      reset = 1'b0;
      checkOutput("reset_mid_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_mid_busy", 32'(busy), 32'd0);
      expQ.delete();
      runOp("replay_after_reset", 1'b0, 20);

      $display("[TB] address wrap");
      tagMem[30] = mkTag(30, 1022, 1, 0);
      romMem[1022] = 8'hA1;
      romMem[1023] = 8'hA2;
      romMem[0]    = 8'hA3;
      romMem[1]    = 8'hA4;
      runOp("wrap", 1'b0, 30);

      $display("[TB] random lookups");
      for (int i = 0; i < 12; i++) begin
         seq = $urandom_range(50, 120);
         len = $urandom_range(1, 16);
         s   = $urandom_range(0, 1023 - len);
         if ($urandom_range(0, 4) == 0)
            tagMem[seq] = mkTag((seq + 1) % 128, s, s + len - 1, 0);
         else
            tagMem[seq] = mkTag(seq, s, s + len - 1, 0);
         randReady = (($urandom_range(0, 1)) == 1);
         runOp("random", 1'b0, seq);
      end
      randReady = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
